vga_timing_detector: RTL and testbench
======================================

// Module: vga_timing_detector
// PURPOSE
//  Receive-side counterpart of the on-chip VGA generator: samples an incoming HS/VS/RGB stream,
//  measures horizontal/vertical totals, sync widths and polarities, and classifies the mode.
//  Sits on the capture path of the resolution demonstrator and reports the detected mode to LEDs/debug.
//  Measurements are taken in CLOCK_25 cycles (horizontal) and in lines (vertical).
// PARAMETERS
//  H_W        12    width of horizontal counters (cycles per line, saturating)
//  V_W        11    width of vertical counters (lines per frame, saturating)
//  A_HTOTAL   800   mode A horizontal total, CLOCK_25 cycles
//  A_VTOTAL   525   mode A vertical total, lines
//  B_HTOTAL   1056  mode B horizontal total, CLOCK_25 cycles
//  B_VTOTAL   628   mode B vertical total, lines
//  H_TOL      4     allowed +/- deviation of h_total for a match and for lock
// PORTS
//  CLOCK_25    in   1    sample clock; all logic on rising edge
//  reset       in   1    asynchronous, active-high
//  HS          in   1    incoming horizontal sync, any polarity, asynchronous
//  VS          in   1    incoming vertical sync, any polarity, asynchronous
//  VGA_RED     in   3    incoming red   (used only with VGA_DET_ACTIVE_EN)
//  VGA_GREEN   in   3    incoming green (used only with VGA_DET_ACTIVE_EN)
//  VGA_BLUE    in   3    incoming blue  (used only with VGA_DET_ACTIVE_EN)
//  h_total     out  H_W  cycles between consecutive HS rising edges (last complete frame)
//  h_pulse     out  H_W  sync pulse width = min(HS high time, HS low time)
//  hs_pol      out  1    1 = HS pulse is the high level
//  v_total     out  V_W  lines between consecutive VS rising edges
//  v_pulse     out  V_W  min(VS high lines, VS low lines)
//  vs_pol      out  1    1 = VS pulse is the high level
//  h_active    out  H_W  non-black pixels on the last full line (0 when feature disabled)
//  mode        out  2    0 unknown, 1 mode A, 2 mode B, 3 reserved (never driven)
//  locked      out  1    stable timing confirmed
//  frame_valid out  1    one-cycle strobe when outputs update at end of frame
// BEHAVIOUR
//  - Reset: every output 0; FSM -> SEARCH; all counters 0.
//  - HS/VS pass through 2-flop synchronizers (2-cycle latency); edges detected on synchronized values.
//  - Line: hcnt increments every cycle, hi/lo counters per HS level; on HS rising edge latch
//    line_total=hcnt, line_pulse=min(hi,lo), line_pol=(hi<lo); clear counters. Tie hi==lo -> pol=0.
//  - Frame: each HS rising edge increments vcnt and VS hi/lo line counters (level from sync VS);
//    on VS rising edge latch frame results, clear vertical counters. Simultaneous HS and VS rising
//    edges: the line is counted into the ending frame first, then vertical counters clear.
//  - Outputs h_*/v_*/h_active update together on VS rising edge; frame_valid pulses that cycle.
//  - Counters saturate at all-ones; no wrap. Saturated hcnt = HS timeout; saturated vcnt = VS timeout.
//  - mode: 1 if |h_total-A_HTOTAL|<=H_TOL and v_total==A_VTOTAL; 2 likewise for B; else 0.
//    A checked first. Registered with the frame outputs.
//  - FSM: SEARCH --first VS rise--> MEASURE --VS rise--> CHECK (1 cycle): same as previous frame
//    (h within H_TOL, v_total exact, polarities equal) -> LOCKED else MEASURE.
//    LOCKED: a mismatching frame or any timeout -> SEARCH, locked=0, mode=0 next cycle.
//  - locked=1 only in LOCKED; asserted the cycle after the second matching frame_valid.
//  - First frame after reset/SEARCH is partial: its frame_valid is suppressed.
//  - Async reset mid-frame discards all partial counts; no output glitch beyond clearing to 0.
// CONFIGURATION
//  - VGA_DET_ACTIVE_EN defined: RGB sampled each cycle; a pixel counts when any bit is 1;
//    per-line count latched on HS rise into h_active at frame end (last line's count).
//  - Not defined: RGB inputs ignored, no counter logic, h_active tied 0.
// TESTING
//  - 640x480 gen, HS neg 96 cycles / total 800, VS neg 2 lines / total 525 -> after 2 frames:
//    h_total=800, h_pulse=96, hs_pol=0, v_total=525, v_pulse=2, vs_pol=0, mode=1, locked=1.
//  - Same timing, positive sync polarities -> identical totals, hs_pol=1, vs_pol=1, mode=1.
//  - Total 1056 x 628 lines -> mode=2; total 803 x 525 -> mode=1; total 810 x 525 -> mode=0, still locks.
//  - While locked, hold HS constant 4096+ cycles -> locked=0 and mode=0 within 1 cycle of saturation;
//    restore HS -> relock after 2 full frames.
//  - Switch mode A to B mid-frame -> locked drops on first mismatching frame, mode=2 after relock.
//  - Assert reset mid-frame -> all outputs 0 immediately; ACTIVE_EN: 640 white pixels/line -> h_active=640.

Source files
------------

// File: rtl/vga_timing_detector.sv
// VGA receive-side timing detector: measures HS/VS totals, pulses, polarities and classifies mode.
// Optional per-line active pixel counter enabled by defining VGA_DET_ACTIVE_EN.
module vga_timing_detector #(
  parameter int H_W      = 12,
  parameter int V_W      = 11,
  parameter int A_HTOTAL = 800,
  parameter int A_VTOTAL = 525,
  parameter int B_HTOTAL = 1056,
  parameter int B_VTOTAL = 628,
  parameter int H_TOL    = 4
) (
  input  logic           CLOCK_25,
  input  logic           reset,
  input  logic           HS,
  input  logic           VS,
  input  logic [2:0]     VGA_RED,
  input  logic [2:0]     VGA_GREEN,
  input  logic [2:0]     VGA_BLUE,
  output logic [H_W-1:0] h_total,
  output logic [H_W-1:0] h_pulse,
  output logic           hs_pol,
  output logic [V_W-1:0] v_total,
  output logic [V_W-1:0] v_pulse,
  output logic           vs_pol,
  output logic [H_W-1:0] h_active,
  output logic [1:0]     mode,
  output logic           locked,
  output logic           frame_valid
);

  typedef enum logic [1:0] {
    SEARCH, MEASURE, CHECK, LOCKED
  } state_t;

  localparam logic [H_W-1:0] A_H = H_W'(A_HTOTAL);
  localparam logic [H_W-1:0] B_H = H_W'(B_HTOTAL);
  localparam logic [H_W-1:0] TOL = H_W'(H_TOL);
  localparam logic [V_W-1:0] A_V = V_W'(A_VTOTAL);
  localparam logic [V_W-1:0] B_V = V_W'(B_VTOTAL);

  function automatic logic [H_W-1:0] hinc(input logic [H_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [V_W-1:0] vinc(input logic [V_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [H_W-1:0] hdiff(
    input logic [H_W-1:0] a,
    input logic [H_W-1:0] b
  );
    return (a > b) ? a - b : b - a;
  endfunction

  logic [2:0] hs_sync, vs_sync;
  logic       hs_rise, vs_rise;

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      hs_sync <= '0;
      vs_sync <= '0;
    end else begin
      hs_sync <= {hs_sync[1:0], HS};
      vs_sync <= {vs_sync[1:0], VS};
    end
  end

  assign hs_rise = hs_sync[1] & ~hs_sync[2];
  assign vs_rise = vs_sync[1] & ~vs_sync[2];

  logic [H_W-1:0] hcnt, hhi, hlo;
  logic [H_W-1:0] line_total, line_pulse;
  logic           line_pol;

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      hcnt       <= '0;
      hhi        <= '0;
      hlo        <= '0;
      line_total <= '0;
      line_pulse <= '0;
      line_pol   <= 1'b0;
    end else if (hs_rise) begin
      line_total <= hcnt;
      line_pulse <= (hhi < hlo) ? hhi : hlo;
      line_pol   <= hhi < hlo;
      hcnt       <= H_W'(1);
      hhi        <= H_W'(1);
      hlo        <= '0;
    end else begin
      hcnt <= hinc(hcnt);
      if (hs_sync[1]) hhi <= hinc(hhi);
      else            hlo <= hinc(hlo);
    end
  end

  // A line ending in the same cycle as VS rise belongs to the ending frame
  logic [H_W-1:0] fr_h_total, fr_h_pulse;
  logic           fr_hs_pol;

  assign fr_h_total = hs_rise ? hcnt : line_total;
  assign fr_h_pulse = hs_rise ? ((hhi < hlo) ? hhi : hlo) : line_pulse;
  assign fr_hs_pol  = hs_rise ? (hhi < hlo) : line_pol;

  logic [V_W-1:0] vcnt, vhi, vlo;
  logic [V_W-1:0] vcnt_n, vhi_n, vlo_n;

  assign vcnt_n = hs_rise ? vinc(vcnt) : vcnt;
  assign vhi_n  = (hs_rise && vs_sync[1]) ? vinc(vhi) : vhi;
  assign vlo_n  = (hs_rise && !vs_sync[1]) ? vinc(vlo) : vlo;

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      vcnt <= '0;
      vhi  <= '0;
      vlo  <= '0;
    end else if (vs_rise) begin
      vcnt <= '0;
      vhi  <= '0;
      vlo  <= '0;
    end else begin
      vcnt <= vcnt_n;
      vhi  <= vhi_n;
      vlo  <= vlo_n;
    end
  end

  logic [V_W-1:0] fr_v_total, fr_v_pulse;
  logic           fr_vs_pol;

  assign fr_v_total = vcnt_n;
  assign fr_v_pulse = (vhi_n < vlo_n) ? vhi_n : vlo_n;
  assign fr_vs_pol  = vhi_n < vlo_n;

  logic [H_W-1:0] fr_h_active;

`ifdef VGA_DET_ACTIVE_EN
  logic [1:0]     pix_d;
  logic [H_W-1:0] pcnt, line_act;

  // Pixel flag delayed to line up with the synchronized HS
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      pix_d    <= '0;
      pcnt     <= '0;
      line_act <= '0;
    end else begin
      pix_d <= {pix_d[0], |{VGA_RED, VGA_GREEN, VGA_BLUE}};
      if (hs_rise) begin
        line_act <= pcnt;
        pcnt     <= H_W'(pix_d[1]);
      end else if (pix_d[1]) begin
        pcnt <= hinc(pcnt);
      end
    end
  end

  assign fr_h_active = hs_rise ? pcnt : line_act;
`else
  logic unused_rgb;
  assign unused_rgb  = ^{VGA_RED, VGA_GREEN, VGA_BLUE};
  assign fr_h_active = '0;
`endif

  logic [1:0] fr_mode;
  logic       timeout, have_ref, match, match_q;

  always_comb begin
    fr_mode = 2'd0;
    if (hdiff(fr_h_total, A_H) <= TOL && fr_v_total == A_V)
      fr_mode = 2'd1;
    else if (hdiff(fr_h_total, B_H) <= TOL && fr_v_total == B_V)
      fr_mode = 2'd2;
  end

  assign timeout = (hcnt == '1) | (vcnt == '1);
  assign match   = have_ref
                 && hdiff(fr_h_total, h_total) <= TOL
                 && fr_v_total == v_total
                 && fr_hs_pol == hs_pol
                 && fr_vs_pol == vs_pol;

  state_t state, state_n;
  logic   latch, drop;

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) state <= SEARCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    latch   = 1'b0;
    unique case (state)
      SEARCH: begin
        if (vs_rise && !timeout) state_n = MEASURE;
      end
      MEASURE: begin
        if (timeout) begin
          state_n = SEARCH;
        end else if (vs_rise) begin
          state_n = CHECK;
          latch   = 1'b1;
        end
      end
      CHECK: begin
        if (timeout)      state_n = SEARCH;
        else if (match_q) state_n = LOCKED;
        else              state_n = MEASURE;
      end
      LOCKED: begin
        if (timeout) begin
          state_n = SEARCH;
        end else if (vs_rise) begin
          latch = 1'b1;
          if (!match) state_n = SEARCH;
        end
      end
    endcase
    drop = (state_n == SEARCH);
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      h_total     <= '0;
      h_pulse     <= '0;
      hs_pol      <= 1'b0;
      v_total     <= '0;
      v_pulse     <= '0;
      vs_pol      <= 1'b0;
      h_active    <= '0;
      mode        <= 2'd0;
      frame_valid <= 1'b0;
      match_q     <= 1'b0;
      have_ref    <= 1'b0;
    end else begin
      frame_valid <= latch;
      if (latch) begin
        h_total  <= fr_h_total;
        h_pulse  <= fr_h_pulse;
        hs_pol   <= fr_hs_pol;
        v_total  <= fr_v_total;
        v_pulse  <= fr_v_pulse;
        vs_pol   <= fr_vs_pol;
        h_active <= fr_h_active;
        mode     <= fr_mode;
        match_q  <= match;
        have_ref <= 1'b1;
      end
      if (drop) begin
        mode     <= 2'd0;
        have_ref <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_detector.sv
// Directed bench for vga_timing_detector using scaled-down modes (A 80x12, B 106x15).
// Table vectors cover polarity/tolerance cases; sequences cover lock, timeout, mode switch, reset.
module tb_vga_timing_detector;

  localparam int H_W = 8;
  localparam int V_W = 6;

`ifdef VGA_DET_ACTIVE_EN
  localparam int EXP_ACT = 40;
`else
  localparam int EXP_ACT = 0;
`endif

  logic           clk;
  logic           reset;
  logic           HS, VS;
  logic [2:0]     red, green, blue;
  logic [H_W-1:0] h_total, h_pulse, h_active;
  logic [V_W-1:0] v_total, v_pulse;
  logic           hs_pol, vs_pol, locked, frame_valid;
  logic [1:0]     mode;

  vga_timing_detector #(
    .H_W(H_W), .V_W(V_W),
    .A_HTOTAL(80), .A_VTOTAL(12),
    .B_HTOTAL(106), .B_VTOTAL(15),
    .H_TOL(4)
  ) dut (
    .CLOCK_25(clk), .reset(reset),
    .HS(HS), .VS(VS),
    .VGA_RED(red), .VGA_GREEN(green), .VGA_BLUE(blue),
    .h_total(h_total), .h_pulse(h_pulse), .hs_pol(hs_pol),
    .v_total(v_total), .v_pulse(v_pulse), .vs_pol(vs_pol),
    .h_active(h_active), .mode(mode),
    .locked(locked), .frame_valid(frame_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ht, hpw, hp, vt, vpw, vp;
    int e_ht, e_hpw, e_hpol, e_vt, e_vpw, e_vpol, e_mode, e_lock;
  } vec_t;

  vec_t vecs[8];
  vec_t cfg_a, cfg_b;
  int   checks = 0;
  int   errors = 0;
  int   fv_cnt = 0;

  always @(negedge clk) if (frame_valid) fv_cnt++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    HS = 1'b0; VS = 1'b0;
    red = '0; green = '0; blue = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    fv_cnt = 0;
  endtask

  // Lines start at y=0; sync pulse occupies the first hpw cycles / vpw lines
  task automatic run_lines(input vec_t c, input int n);
    for (int l = 0; l < n; l++) begin
      int y;
      y = l % c.vt;
      for (int x = 0; x < c.ht; x++) begin
        @(negedge clk);
        HS = ((x < c.hpw) == (c.hp != 0));
        VS = ((y < c.vpw) == (c.vp != 0));
        red   = (x >= 20 && x < 60) ? 3'b111 : 3'b000;
        green = red;
        blue  = red;
      end
    end
  endtask

  initial begin
    vecs[0] = '{80, 10, 0, 12, 2, 0,  80, 10, 0, 12, 2, 0, 1, 1};
    vecs[1] = '{80, 10, 1, 12, 2, 1,  80, 10, 1, 12, 2, 1, 1, 1};
    vecs[2] = '{106, 12, 0, 15, 3, 0, 106, 12, 0, 15, 3, 0, 2, 1};
    vecs[3] = '{83, 10, 0, 12, 2, 0,  83, 10, 0, 12, 2, 0, 1, 1};
    vecs[4] = '{86, 10, 0, 12, 2, 0,  86, 10, 0, 12, 2, 0, 0, 1};
    vecs[5] = '{80, 10, 1, 12, 2, 0,  80, 10, 1, 12, 2, 0, 1, 1};
    vecs[6] = '{80, 40, 1, 12, 2, 1,  80, 40, 0, 12, 2, 1, 1, 1};
    vecs[7] = '{80, 10, 0, 13, 2, 0,  80, 10, 0, 13, 2, 0, 0, 1};
    cfg_a = vecs[0];
    cfg_b = vecs[2];

    do_reset();
    chk("rst h_total", int'(h_total), 0);
    chk("rst v_total", int'(v_total), 0);
    chk("rst mode", int'(mode), 0);
    chk("rst locked", int'(locked), 0);
    chk("rst frame_valid", int'(frame_valid), 0);
    chk("rst h_active", int'(h_active), 0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      run_lines(vecs[i], 4 * vecs[i].vt);
      chk($sformatf("v%0d h_total", i), int'(h_total), vecs[i].e_ht);
      chk($sformatf("v%0d h_pulse", i), int'(h_pulse), vecs[i].e_hpw);
      chk($sformatf("v%0d hs_pol", i), int'(hs_pol), vecs[i].e_hpol);
      chk($sformatf("v%0d v_total", i), int'(v_total), vecs[i].e_vt);
      chk($sformatf("v%0d v_pulse", i), int'(v_pulse), vecs[i].e_vpw);
      chk($sformatf("v%0d vs_pol", i), int'(vs_pol), vecs[i].e_vpol);
      chk($sformatf("v%0d mode", i), int'(mode), vecs[i].e_mode);
      chk($sformatf("v%0d locked", i), int'(locked), vecs[i].e_lock);
      chk($sformatf("v%0d h_active", i), int'(h_active), EXP_ACT);
      chk($sformatf("v%0d fv_count", i), fv_cnt, 3);
    end

    // Lock sequence: partial frame suppressed, then two measured frames
    do_reset();
    run_lines(cfg_a, 24);
    chk("lock early locked", int'(locked), 0);
    chk("lock early mode", int'(mode), 1);
    chk("lock early fv", fv_cnt, 1);
    run_lines(cfg_a, 12);
    chk("lock locked", int'(locked), 1);
    run_lines(cfg_a, 12);

    // HS/VS stall while locked
    repeat (120) @(negedge clk);
    chk("stall pre locked", int'(locked), 1);
    chk("stall pre mode", int'(mode), 1);
    repeat (140) @(negedge clk);
    chk("stall locked", int'(locked), 0);
    chk("stall mode", int'(mode), 0);
    run_lines(cfg_a, 24);
    chk("relock early locked", int'(locked), 0);
    run_lines(cfg_a, 12);
    chk("relock locked", int'(locked), 1);
    chk("relock mode", int'(mode), 1);

    // Switch A to B in the middle of a frame
    run_lines(cfg_a, 6);
    run_lines(cfg_b, 15);
    chk("switch locked", int'(locked), 0);
    chk("switch mode", int'(mode), 0);
    run_lines(cfg_b, 45);
    chk("switch relock", int'(locked), 1);
    chk("switch mode b", int'(mode), 2);
    chk("switch h_total", int'(h_total), 106);
    chk("switch v_total", int'(v_total), 15);

    // Asynchronous reset mid-frame
    run_lines(cfg_b, 7);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset locked", int'(locked), 0);
    chk("areset mode", int'(mode), 0);
    chk("areset h_total", int'(h_total), 0);
    chk("areset v_total", int'(v_total), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
